fetch_queue: RTL and testbench
==============================

# fetch_queue

Instruction-fetch stage with a small prefetch FIFO between the instruction memory and the IF/ID pipeline register. Owns the program counter, reads the combinational instruction memory, and queues each instruction with its PC+4. Presents them to IF/ID under a valid/ready handshake. Flushes and redirects on a taken branch/jump from the MEM stage, so the datapath can stall IF/ID without losing fetched instructions.

## Interface
Parameters:
- DEPTH, 4, FIFO entries; power of two, 2..16
- RESET_PC, 32'h0000_0000, PC loaded on reset
- IMEM_WORDS, 256, instruction memory size in words; fetch beyond it halts

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- imem_addr  out  32  byte address to instruction memory, equals fetch PC
- imem_data  in  32  instruction word at imem_addr, combinational, same cycle
- redirect_en  in  1  taken branch/jump from MEM stage
- redirect_pc  in  32  target address, valid with redirect_en
- out_valid  out  1  head entry valid
- out_ready  in  1  IF/ID accepts head this cycle (low = stall)
- out_ins  out  32  head instruction; 32'h0000_0000 (nop) when out_valid=0
- out_pc4  out  32  head PC+4; 0 when out_valid=0
- halted  out  1  fetch FSM in HALT
- perf_flush_cnt  out  16  present only with FETCH_PERF_EN
- perf_full_cnt  out  16  present only with FETCH_PERF_EN

## Operation
- FSM states: RUN, HALT.
- RUN, push rule: push {imem_data, fetch_pc+4} when the FIFO is not full, or when it is full and a pop happens in the same cycle. On push, fetch_pc += 4.
- Pop rule: pop when out_valid && out_ready. The head advances at the clock edge.
- Halt instruction: imem_data[31:26] == 6'b111111 is pushed normally. fetch_pc is not advanced, and the FSM goes to HALT.
- Out of range: fetch_pc >= IMEM_WORDS*4 in RUN causes no push and a move to HALT.
- HALT: no pushes. Draining by pops continues normally.
- Redirect (any state), at the clock edge:
  - FIFO cleared (count=0).
  - fetch_pc <= redirect_pc.
  - FSM goes to RUN.
  - No push and no pop take effect that cycle.
- Redirect has priority over push, pop, halt detection and out-of-range.
- PC arithmetic is 32-bit modulo 2^32. redirect_pc[1:0] are forced to 0.
- Count is held as (DEPTH-index) pointers plus a count register. Full = count==DEPTH; empty = count==0.

## Timing
- Reset values:
  - fetch_pc=RESET_PC, count=0, rd/wr pointers=0, state=RUN
  - out_valid=0, out_ins=0, out_pc4=0, halted=0
  - perf counters=0
- Fetch-to-output latency is 1 cycle: an instruction pushed in cycle N is at the head with out_valid=1 in cycle N+1 if the FIFO was empty.
- First cycle with rst low: imem_addr=RESET_PC. out_valid rises the following cycle.
- Redirect asserted in cycle N:
  - imem_addr=redirect_pc in N+1.
  - out_valid=0 in N+1.
  - The target instruction appears in N+2.
- Simultaneous push and pop at full: count unchanged, both occur.
- Simultaneous push and pop at empty: the push is accepted; the pop is impossible since out_valid=0.
- rst asserted mid-operation overrides redirect and returns all state to reset values at the next edge.
- halted is a registered output: 1 in the cycle after HALT is entered.

## Configuration
- FETCH_PERF_EN defined: adds perf_flush_cnt and perf_full_cnt, both saturating at 16'hFFFF and cleared by rst.
  - perf_flush_cnt increments on each redirect that discards at least one valid entry.
  - perf_full_cnt increments on each RUN cycle where a push is blocked because the FIFO is full.
- FETCH_PERF_EN undefined: both ports and the counter logic are absent; all other behaviour is identical.

## Structure
- Package fetch_pkg holds:
  - fetch_entry_t struct {ins[31:0], pc4[31:0]}
  - state enum {RUN, HALT}
  - HALT_OPCODE = 6'b111111
  - NOP_INS = 32'h0
- One sub-module, fetch_fifo: a parameterised DEPTH-entry synchronous FIFO of fetch_entry_t with push, pop, flush, full, empty and head outputs.
- fetch_queue holds the PC, the FSM and the push/pop/redirect arbitration.

## Test plan
- Reset, out_ready=1, imem returns 0x20080005 at 0x0 and 0x20090003 at 0x4.
  - Required: out_valid rises the cycle after rst falls.
  - Required: out_ins=0x20080005/out_pc4=0x4, then 0x20090003/0x8 on consecutive cycles.
- out_ready=0 for 8 cycles after reset, DEPTH=4.
  - Required: exactly 4 pushes, imem_addr frozen at 0x10, count stays 4.
  - Required: raising out_ready drains 0x0..0xC entries in order.
- Redirect_en with redirect_pc=0x40 while the FIFO holds 3 entries.
  - Required: the next cycle has out_valid=0 and imem_addr=0x40.
  - Required: the cycle after, out_pc4=0x44.
  - With FETCH_PERF_EN: perf_flush_cnt=1.
- Halt word 0xFC000000 at 0x8.
  - Required: it is delivered with out_pc4=0xC, then halted=1.
  - Required: no further pushes; imem_addr stays 0x8 until a redirect to 0x0 restarts fetch.
- IMEM_WORDS=4, straight-line code.
  - Required: the push of 0xC is the last; halted=1 with fetch_pc=0x10.
- rst asserted in the same cycle as redirect_en to 0x80.
  - Required: the next cycle has imem_addr=RESET_PC and out_valid=0.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch queue.
// Pure declarations: no latency, no flow control.
// FETCH_PERF_EN (see fetch_queue) does not affect this package.
package fetch_pkg;

    typedef struct packed {
        logic [31:0] ins;
        logic [31:0] pc4;
    } fetch_entry_t;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } state_t;

    localparam logic [5:0]  HALT_OPCODE = 6'b111111;
    localparam logic [31:0] NOP_INS     = 32'h0000_0000;

    function automatic logic is_halt(input logic [31:0] ins);
        return ins[31:26] == HALT_OPCODE;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// DEPTH-entry synchronous FIFO of fetch entries; head is read combinationally.
// Latency: a push is visible at the head on the next cycle; flush empties it at the edge.
// Backpressure: caller must not push when full (unless popping) nor pop when empty.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  fetch_entry_t push_entry,
    output fetch_entry_t head,
    output logic         full,
    output logic         empty
);

    localparam int AW = $clog2(DEPTH);

    fetch_entry_t   mem [DEPTH];
    logic [AW-1:0]  rd_ptr;
    logic [AW-1:0]  wr_ptr;
    logic [AW:0]    count;

    assign full  = (count == (AW+1)'(DEPTH));
    assign empty = (count == '0);
    assign head  = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage carries no reset; validity is tracked entirely by count.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_entry;
    end

endmodule

// File: rtl/fetch_queue.sv
// Fetch stage: owns the PC, reads imem, queues {ins, pc+4} for IF/ID; FETCH_PERF_EN adds perf counters.
// Latency: fetch-to-head 1 cycle when empty; a redirect clears the queue and shows the target 2 cycles later.
// Backpressure: out_ready low holds the head; fetch stalls once the queue is full.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int          DEPTH      = 4,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          IMEM_WORDS = 256
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_data,
    input  logic        redirect_en,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_ins,
    output logic [31:0] out_pc4,
    output logic        halted
`ifdef FETCH_PERF_EN
    ,
    output logic [15:0] perf_flush_cnt,
    output logic [15:0] perf_full_cnt
`endif
);

    localparam logic [32:0] PC_LIMIT = 33'(IMEM_WORDS) * 33'd4;

    state_t       state;
    logic [31:0]  fetch_pc;
    fetch_entry_t head;
    fetch_entry_t push_entry;
    logic         full;
    logic         empty;
    logic         in_range;
    logic         fetch_ok;
    logic         do_push;
    logic         do_pop;

    // Redirect suppresses both push and pop so the flush wins cleanly.
    assign in_range   = ({1'b0, fetch_pc} < PC_LIMIT);
    assign do_pop     = !empty && out_ready && !redirect_en;
    assign fetch_ok   = (state == RUN) && !redirect_en && in_range;
    assign do_push    = fetch_ok && (!full || do_pop);
    assign push_entry = '{ins: imem_data, pc4: fetch_pc + 32'd4};

    assign imem_addr = fetch_pc;
    assign out_valid = !empty;
    assign out_ins   = empty ? NOP_INS : head.ins;
    assign out_pc4   = empty ? 32'h0   : head.pc4;

    fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (do_push),
        .pop        (do_pop),
        .flush      (redirect_en),
        .push_entry (push_entry),
        .head       (head),
        .full       (full),
        .empty      (empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= RUN;
            fetch_pc <= RESET_PC;
            halted   <= 1'b0;
        end else if (redirect_en) begin
            state    <= RUN;
            fetch_pc <= redirect_pc & ~32'h3;
            halted   <= 1'b0;
        end else if (state == RUN) begin
            if (!in_range) begin
                state  <= HALT;
                halted <= 1'b1;
            end else if (do_push) begin
                // A halt word is queued but the PC stays on it.
                if (is_halt(imem_data)) begin
                    state  <= HALT;
                    halted <= 1'b1;
                end else begin
                    fetch_pc <= fetch_pc + 32'd4;
                end
            end
        end
    end

`ifdef FETCH_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_flush_cnt <= '0;
            perf_full_cnt  <= '0;
        end else begin
            if (redirect_en && !empty && perf_flush_cnt != 16'hFFFF)
                perf_flush_cnt <= perf_flush_cnt + 16'd1;
            if (fetch_ok && full && !do_pop && perf_full_cnt != 16'hFFFF)
                perf_full_cnt <= perf_full_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// Directed plus random bench for fetch_queue against a queue-based reference model.
module tb_fetch_queue;

    localparam int          DEPTH = 4;
    localparam int          WORDS = 32;
    localparam logic [31:0] RPC   = 32'h0000_0000;
    localparam logic [31:0] LIM   = 32'(WORDS * 4);

    logic        clk = 1'b0;
    logic        rst, redirect_en, out_ready, out_valid, halted;
    logic [31:0] imem_addr, imem_data, redirect_pc, out_ins, out_pc4;
`ifdef FETCH_PERF_EN
    logic [15:0] perf_flush_cnt, perf_full_cnt;
    int          m_flush, m_full;
`endif

    logic [31:0] imem [WORDS];
    int          checks = 0;
    int          errors = 0;

    logic [31:0] q_ins[$];
    logic [31:0] q_pc4[$];
    logic [31:0] m_pc;
    logic        m_run;
    logic        m_known = 1'b0;

    always #5 clk = ~clk;

    always_comb imem_data = (imem_addr < LIM) ? imem[imem_addr[6:2]] : 32'hDEAD_BEEF;

    fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RPC), .IMEM_WORDS(WORDS)) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_addr      (imem_addr),
        .imem_data      (imem_data),
        .redirect_en    (redirect_en),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_ins        (out_ins),
        .out_pc4        (out_pc4),
        .halted         (halted)
`ifdef FETCH_PERF_EN
        ,
        .perf_flush_cnt (perf_flush_cnt),
        .perf_full_cnt  (perf_full_cnt)
`endif
    );

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (a < LIM) return imem[a[6:2]];
        return 32'hDEAD_BEEF;
    endfunction

    function automatic logic [31:0] plain_word();
        logic [31:0] w;
        w = $urandom;
        if (w[31:26] == 6'h3F) w[31] = 1'b0;
        return w;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_model();
        if (!m_known) return;
        chk("imem_addr", imem_addr, m_pc);
        chk("out_valid", 32'(out_valid), 32'(q_ins.size() > 0));
        chk("out_ins",   out_ins, (q_ins.size() > 0) ? q_ins[0] : 32'h0);
        chk("out_pc4",   out_pc4, (q_pc4.size() > 0) ? q_pc4[0] : 32'h0);
        chk("halted",    32'(halted), 32'(!m_run));
`ifdef FETCH_PERF_EN
        chk("perf_flush", 32'(perf_flush_cnt), 32'(m_flush));
        chk("perf_full",  32'(perf_full_cnt),  32'(m_full));
`endif
    endtask

    // Reference behaviour at one clock edge, from the sampled inputs.
    task automatic model_edge();
        logic        pop, push, ok;
        logic [31:0] w;
        if (rst) begin
            q_ins.delete(); q_pc4.delete();
            m_pc = RPC; m_run = 1'b1; m_known = 1'b1;
`ifdef FETCH_PERF_EN
            m_flush = 0; m_full = 0;
`endif
        end else if (!m_known) begin
            return;
        end else if (redirect_en) begin
`ifdef FETCH_PERF_EN
            if (q_ins.size() > 0 && m_flush < 65535) m_flush++;
`endif
            q_ins.delete(); q_pc4.delete();
            m_pc  = redirect_pc & ~32'h3;
            m_run = 1'b1;
        end else begin
            pop  = (q_ins.size() > 0) && out_ready;
            ok   = m_run && (m_pc < LIM);
            push = ok && (q_ins.size() < DEPTH || pop);
`ifdef FETCH_PERF_EN
            if (ok && q_ins.size() == DEPTH && !pop && m_full < 65535) m_full++;
`endif
            if (m_run && !(m_pc < LIM)) m_run = 1'b0;
            if (pop) begin
                void'(q_ins.pop_front());
                void'(q_pc4.pop_front());
            end
            if (push) begin
                w = mem_rd(m_pc);
                q_ins.push_back(w);
                q_pc4.push_back(m_pc + 32'd4);
                if (w[31:26] == 6'h3F) m_run = 1'b0;
                else                   m_pc  = m_pc + 32'd4;
            end
        end
    endtask

    task automatic tick(input logic r, input logic re, input logic [31:0] rp, input logic rdy);
        rst = r; redirect_en = re; redirect_pc = rp; out_ready = rdy;
        @(negedge clk);
        check_model();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    initial begin
        rst = 1'b1; redirect_en = 1'b0; redirect_pc = '0; out_ready = 1'b0;
        for (int i = 0; i < WORDS; i++) imem[i] = plain_word();
        imem[0] = 32'h2008_0005;
        imem[1] = 32'h2009_0003;

        // Reset, then first two instructions stream out back to back.
        tick(1, 0, 0, 1);
        chk("rst_valid", 32'(out_valid), 32'h0);
        chk("rst_ins",   out_ins, 32'h0);
        chk("rst_addr",  imem_addr, RPC);
        tick(0, 0, 0, 1);
        chk("first_valid", 32'(out_valid), 32'h1);
        chk("first_ins",   out_ins, 32'h2008_0005);
        chk("first_pc4",   out_pc4, 32'h4);
        tick(0, 0, 0, 1);
        chk("second_ins",  out_ins, 32'h2009_0003);
        chk("second_pc4",  out_pc4, 32'h8);

        // Stall fills the queue and freezes the PC, then drains in order.
        tick(1, 0, 0, 0);
        for (int i = 0; i < 8; i++) tick(0, 0, 0, 0);
        chk("stall_addr", imem_addr, 32'h10);
        chk("stall_ins",  out_ins, imem[0]);
        for (int i = 0; i < 4; i++) begin
            chk("drain_pc4", out_pc4, 32'(4 * i + 4));
            tick(0, 0, 0, 1);
        end

        // Redirect with three entries queued.
        tick(1, 0, 0, 0);
        for (int i = 0; i < 3; i++) tick(0, 0, 0, 0);
        tick(0, 1, 32'h40, 0);
        chk("redir_valid", 32'(out_valid), 32'h0);
        chk("redir_addr",  imem_addr, 32'h40);
        tick(0, 0, 0, 1);
        chk("redir_pc4",   out_pc4, 32'h44);
`ifdef FETCH_PERF_EN
        chk("redir_flush", 32'(perf_flush_cnt), 32'h1);
`endif

        // Halt word at 0x8.
        imem[2] = 32'hFC00_0000;
        tick(1, 0, 0, 1);
        for (int i = 0; i < 3; i++) tick(0, 0, 0, 1);
        chk("halt_ins", out_ins, 32'hFC00_0000);
        chk("halt_pc4", out_pc4, 32'hC);
        chk("halted",   32'(halted), 32'h1);
        for (int i = 0; i < 3; i++) tick(0, 0, 0, 1);
        chk("halt_addr",  imem_addr, 32'h8);
        chk("halt_empty", 32'(out_valid), 32'h0);
        tick(0, 1, 32'h0, 1);
        chk("restart_addr", imem_addr, 32'h0);
        chk("restart_run",  32'(halted), 32'h0);
        imem[2] = plain_word();

        // Running off the end of instruction memory.
        tick(0, 1, LIM - 32'h10, 1);
        for (int i = 0; i < 6; i++) tick(0, 0, 0, 1);
        chk("oor_halted", 32'(halted), 32'h1);
        chk("oor_addr",   imem_addr, LIM);

        // Reset wins over a simultaneous redirect.
        tick(0, 0, 0, 1);
        tick(1, 1, 32'h80, 1);
        chk("rst_redir_addr",  imem_addr, RPC);
        chk("rst_redir_valid", 32'(out_valid), 32'h0);

        // Random traffic against the reference model.
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 7) == 0)
                imem[$urandom_range(0, WORDS - 1)] =
                    ($urandom_range(0, 5) == 0) ? {6'h3F, 26'($urandom)} : plain_word();
            tick($urandom_range(0, 79) == 0,
                 $urandom_range(0, 11) == 0,
                 32'($urandom_range(0, 32'h90)),
                 $urandom_range(0, 2) != 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
